// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: time-shares one combinational 10-bit signed ALU among NUM_REQ
// requesters. Only one op is in flight, so the sequence is IDLE -> EXEC -> RESP -> IDLE.
//
// Ports
//   i_clk, i_rst            clock; asynchronous active-high reset
//   i_req_valid/arg0/arg1/oper
//                           per-requester requests, packed with requester k in lane k
//   o_req_ready             one-hot accept strobe (combinational, IDLE only)
//   o_alu_arg0/arg1/oper    registered operands driving the external ALU
//   i_alu_result/flag       ALU outputs, combinational from o_alu_*; flags are {ovf,zero,pos,neg}
//   o_rsp_valid/id/result/flag, i_rsp_ready
//                           tagged response with valid/ready handshake
//   o_busy                  high whenever the FSM is not in IDLE
module alu_rr_scheduler #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  input  logic [NUM_REQ*10-1:0]   i_req_arg0,
  input  logic [NUM_REQ*10-1:0]   i_req_arg1,
  input  logic [NUM_REQ*3-1:0]    i_req_oper,
  output logic [NUM_REQ-1:0]      o_req_ready,
  output logic [9:0]              o_alu_arg0,
  output logic [9:0]              o_alu_arg1,
  output logic [2:0]              o_alu_oper,
  input  logic [9:0]              i_alu_result,
  input  logic [3:0]              i_alu_flag,
  output logic                    o_rsp_valid,
  output logic [ID_W-1:0]         o_rsp_id,
  output logic [9:0]              o_rsp_result,
  output logic [3:0]              o_rsp_flag,
  input  logic                    i_rsp_ready,
  output logic                    o_busy
);

  localparam int unsigned DATA_W = 10;
  localparam int unsigned OPER_W = 3;
  localparam int unsigned SUM_W  = ID_W + 1;
  localparam int unsigned DBL_W  = 2 * NUM_REQ;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [DBL_W-1:0]    valid_rot;
  logic [SUM_W-1:0]    grant_sum;
  logic                grant_vld;
  logic [ID_W-1:0]     grant_id;
  logic [DATA_W-1:0]   sel_arg0;
  logic [DATA_W-1:0]   sel_arg1;
  logic [OPER_W-1:0]   sel_oper;

  // Rotating-priority search: rotate the doubled valid vector so rr_ptr lands at bit 0,
  // take the first set bit, then map the offset back to an index modulo NUM_REQ.
  always_comb begin
    valid_rot = DBL_W'({i_req_valid, i_req_valid} >> rr_ptr);
    grant_sum = '0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_vld && valid_rot[i]) begin
        grant_vld = 1'b1;
        grant_sum = SUM_W'(rr_ptr) + SUM_W'(i);
        if (grant_sum >= SUM_W'(NUM_REQ)) begin
          grant_sum = grant_sum - SUM_W'(NUM_REQ);
        end
        grant_id = ID_W'(grant_sum);
      end
    end
  end

  // Operand lane select for the granted requester.
  always_comb begin
    sel_arg0 = '0;
    sel_arg1 = '0;
    sel_oper = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == grant_id) begin
        sel_arg0 = i_req_arg0[k*DATA_W +: DATA_W];
        sel_arg1 = i_req_arg1[k*DATA_W +: DATA_W];
        sel_oper = i_req_oper[k*OPER_W +: OPER_W];
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and accept strobe; ready is forced low while reset is asserted.
  always_comb begin
    state_nxt   = state;
    o_req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          o_req_ready = NUM_REQ'(1) << grant_id;
          state_nxt   = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (i_rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (i_rst) begin
      o_req_ready = '0;
    end
  end

  // Operand, response and round-robin pointer registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr       <= '0;
      o_alu_arg0   <= '0;
      o_alu_arg1   <= '0;
      o_alu_oper   <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_id     <= '0;
      o_rsp_result <= '0;
      o_rsp_flag   <= '0;
      o_busy       <= 1'b0;
    end else begin
      o_busy <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (grant_vld) begin
            o_alu_arg0 <= sel_arg0;
            o_alu_arg1 <= sel_arg1;
            o_alu_oper <= sel_oper;
            o_rsp_id   <= grant_id;
          end
        end
        EXEC: begin
          o_rsp_result <= i_alu_result;
          o_rsp_flag   <= i_alu_flag;
          o_rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            // Next search starts just past the requester that was served.
            rr_ptr <= (o_rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : o_rsp_id + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
